// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the add/shift multiplier controller:
//   - MULT_N_BITS  : default operand width (number of add/shift steps)
//   - mult_state_t : controller state encoding
//   - cnt_width()  : step-counter width for a given operand width
// No ports (package).
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_N_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HALT  = 3'd4
  } mult_state_t;

  // $clog2(1) is 0, which would give a zero-width counter; keep at least 1 bit.
  function automatic int cnt_width(input int n_bits);
    return (n_bits > 1) ? $clog2(n_bits) : 1;
  endfunction

endpackage

// File: rtl/mult_step_counter.sv
// -----------------------------------------------------------------------------
// mult_step_counter
// Counts completed add/shift steps of one multiply.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset, forces count to 0
//   clear  : synchronous clear (start of a multiply), wins over incr
//   incr   : advance the count by one
//   tc     : terminal count, high while count == N_BITS-1
// -----------------------------------------------------------------------------
module mult_step_counter
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_N_BITS,
  parameter int CNT_W  = cnt_width(N_BITS)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (incr) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(N_BITS - 1));

endmodule

// File: rtl/mult_control.sv
// -----------------------------------------------------------------------------
// mult_control
// Sequencer for an add/shift multiplier (X:A:B datapath). One Run press gives
// exactly one N_BITS-step multiply; Done is held until Run is released.
//
// Build option: define MULT_CONTROL_SIGNED_EN to subtract (rather than add)
// the multiplicand on the last step, giving two's-complement multiplication.
// Without it every step adds and Sub is constant 0.
//
// Ports:
//   Clk          : clock, rising edge
//   Reset        : synchronous active-high reset -> IDLE, step count 0
//   Run          : level request to start a multiply
//   ClearA_LoadB : level request (IDLE only) to clear A/X and load B
//   M            : current multiplier LSB (B shift-out)
//   Clr_A        : clear A register and X bit
//   Ld_B         : load B from switches
//   Ld_A         : load adder result into A and X (= Add | Sub)
//   Add          : adder computes A+S
//   Sub          : adder computes A-S
//   Shift_En     : shift X, A, B right by one
//   Done         : product valid in A:B
// -----------------------------------------------------------------------------
module mult_control
  import mult_pkg::*;
#(
  parameter int N_BITS = MULT_N_BITS
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic M,
  output logic Clr_A,
  output logic Ld_B,
  output logic Ld_A,
  output logic Add,
  output logic Sub,
  output logic Shift_En,
  output logic Done
);

  mult_state_t state_q;
  mult_state_t state_d;

  logic cnt_clear;
  logic cnt_incr;
  logic cnt_tc;

  // START zeroes the counter; SHIFT advances it unless this was the last step.
  assign cnt_clear = (state_q == S_START);
  assign cnt_incr  = (state_q == S_SHIFT) && !cnt_tc;

  mult_step_counter #(
    .N_BITS (N_BITS)
  ) u_step_counter (
    .clk   (Clk),
    .reset (Reset),
    .clear (cnt_clear),
    .incr  (cnt_incr),
    .tc    (cnt_tc)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Run/ClearA_LoadB only matter in IDLE and HALT.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // A clear/load request takes priority over starting a multiply.
        if (!ClearA_LoadB && Run) begin
          state_d = S_START;
        end
      end
      S_START: state_d = S_ADD;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = cnt_tc ? S_HALT : S_ADD;
      S_HALT: begin
        // Wait for Run to drop so a held button cannot retrigger.
        if (!Run) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: current state, plus M in ADD; the IDLE clear/load strobe
  // follows its request level.
  always_comb begin
    Clr_A    = 1'b0;
    Ld_B     = 1'b0;
    Ld_A     = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        Clr_A = ClearA_LoadB;
        Ld_B  = ClearA_LoadB;
      end
      S_START: Clr_A = 1'b1;
      S_ADD: begin
        if (M) begin
          Ld_A = 1'b1;
`ifdef MULT_CONTROL_SIGNED_EN
          // The multiplier MSB carries weight -2^(N-1): subtract on the last step.
          Sub = cnt_tc;
          Add = !cnt_tc;
`else
          Add = 1'b1;
`endif
        end
      end
      S_SHIFT: Shift_En = 1'b1;
      S_HALT:  Done     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mult_control.md
MULT_CONTROL -- requirements
Module: mult_control

Interface
REQ-001 The block SHALL have parameter N_BITS, default 8: number of add/shift steps per multiply, equal to the operand width of the shift registers it drives.
REQ-002 The block SHALL have port Clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have port Run, input, 1: level request to start a multiply, already debounced and synchronised.
REQ-005 The block SHALL have port ClearA_LoadB, input, 1: level request to clear A and load B.
REQ-006 The block SHALL have port M, input, 1: current multiplier LSB (B register Shift_Out).
REQ-007 The block SHALL have port Clr_A, output, 1: synchronous clear of the A register and X bit.
REQ-008 The block SHALL have port Ld_B, output, 1: load the B register from switches.
REQ-009 The block SHALL have port Ld_A, output, 1: load the adder result into A and X.
REQ-010 The block SHALL have port Add, output, 1: the adder computes A+S this step.
REQ-011 The block SHALL have port Sub, output, 1: the adder computes A-S this step.
REQ-012 The block SHALL have port Shift_En, output, 1: shift X, A and B right by one, simultaneously.
REQ-013 The block SHALL have port Done, output, 1: the result is valid in A:B.

Function
REQ-014 The block SHALL implement states IDLE, START, ADD, SHIFT and HALT, plus a step counter of width $clog2(N_BITS).
REQ-015 In IDLE, the block SHALL assert Clr_A and Ld_B for each cycle ClearA_LoadB=1 and remain in IDLE.
REQ-016 In IDLE, Run=1 with ClearA_LoadB=0 SHALL cause a transition to START; ClearA_LoadB SHALL win when both are 1.
REQ-017 In START, the block SHALL assert Clr_A for exactly one cycle, zero the counter and go to ADD.
REQ-018 In ADD, when M=1, the block SHALL assert Ld_A and either Add or Sub; when M=0, it SHALL assert no outputs. The next state SHALL be SHIFT.
REQ-019 In SHIFT, the block SHALL assert Shift_En for one cycle. It SHALL go to HALT when the counter equals N_BITS-1; otherwise it SHALL increment the counter and go to ADD.
REQ-020 In HALT, the block SHALL assert Done, stay in HALT while Run=1, and go to IDLE on the first cycle Run=0, so one Run press yields exactly one multiply.
REQ-021 Add and Sub SHALL never be asserted together; Ld_A SHALL equal Add OR Sub.
REQ-022 Run and ClearA_LoadB SHALL be ignored in START, ADD and SHIFT.
REQ-023 Latency SHALL be: Run sampled in IDLE, then 1+2*N_BITS cycles, then Done=1 (cycle 18 for N_BITS=8).
REQ-024 Outputs SHALL be decoded from the current state, plus M in ADD only; there SHALL be no other combinational input-to-output paths.

Reset
REQ-025 Reset=1 SHALL force IDLE and counter=0 on the next edge from any state, including mid-operation.
REQ-026 While in reset and on the cycle after it, all outputs SHALL be 0.

Configuration
REQ-027 With macro MULT_CONTROL_SIGNED_EN defined, ADD on the last step (counter=N_BITS-1) with M=1 SHALL assert Sub instead of Add, giving two's-complement multiplication.
REQ-028 Without MULT_CONTROL_SIGNED_EN, every step SHALL use Add (unsigned multiply), and Sub SHALL be tied to 0.

Structure
REQ-029 Package mult_pkg SHALL hold the state enum typedef (mult_state_t) and the default operand-width constant MULT_N_BITS=8.
REQ-030 The step counter SHALL be a separate sub-module, mult_step_counter, with clear, increment and terminal-count ports.

Verification
REQ-031 Stimulus Reset, then ClearA_LoadB=1 for 2 cycles -> Clr_A=Ld_B=1 for exactly those 2 cycles; no other outputs asserted.
REQ-032 Stimulus Run=1 held, M sequence per step 1,0,1,0,0,0,0,0 (B=0x05) -> Add in steps 0 and 2 only, 8 Shift_En pulses, Done=1 at cycle 18, Done held while Run=1.
REQ-033 Stimulus MULT_CONTROL_SIGNED_EN defined, M=1 only at step 7 (B=0x80) -> Sub=1 at step 7, Add never asserted; with the macro undefined -> Add=1 at step 7.
REQ-034 Stimulus Reset=1 at cycle 9 of a multiply -> IDLE next edge, all outputs 0, counter 0; a subsequent Run performs a full 8-step multiply.
REQ-035 Stimulus ClearA_LoadB=1 during ADD/SHIFT, and Run re-held after Done -> no Clr_A or Ld_B pulses; a second multiply starts only after Run drops to 0 and rises again.
